// File: rtl/uart_mmio_pkg.sv
// Shared constants for the MMIO UART controller: I/O window, register offsets,
// status bit positions and the occupancy field location.
package uart_mmio_pkg;

  localparam logic [3:0] IO_WIN = 4'h8;

  localparam logic [4:0] RX_CTRL = 5'h00;
  localparam logic [4:0] RX_DATA = 5'h04;
  localparam logic [4:0] TX_CTRL = 5'h08;
  localparam logic [4:0] TX_DATA = 5'h0C;
  localparam logic [4:0] CYCLE   = 5'h10;

  localparam int NOT_EMPTY = 0;
  localparam int NOT_FULL  = 0;
  localparam int OVERFLOW  = 1;
  localparam int OCC_LSB   = 8;

  // Word-aligned register offset; the byte lane bits are ignored.
  function automatic logic [4:0] reg_off(input logic [4:0] a);
    return {a[4:2], 2'b00};
  endfunction

endpackage

// File: rtl/uart_mmio_ctrl_if.sv
// CPU-side load/store port of the MMIO UART controller.
interface uart_mmio_ctrl_if;
  logic        stall;
  logic [31:0] io_addr;
  logic        io_re;
  logic        io_we;
  logic [7:0]  io_wdata;
  logic [31:0] io_rdata;

  modport master (output stall, io_addr, io_re, io_we, io_wdata, input io_rdata);
  modport slave  (input stall, io_addr, io_re, io_we, io_wdata, output io_rdata);
endinterface

// File: rtl/uart_mmio_ctrl_byte_fifo.sv
// Synchronous first-word-fall-through FIFO; push when full and pop when empty
// are ignored, so callers may present requests without pre-gating.
module byte_fifo #(
  parameter int DEPTH_LOG2 = 3,
  parameter int W          = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [W-1:0]        din,
  input  logic                pop,
  output logic [W-1:0]        dout,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] count
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [W-1:0]          mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic                  do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // Empty head reads as zero so reset and empty reads never leak stale bytes.
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// MMIO UART controller: decodes the 0x8xxxxxxx window, buffers RX/TX bytes in
// FIFOs, registers load data. Optional cycle counter: IO_CYCLE_COUNTER_EN.
module uart_mmio_ctrl
  import uart_mmio_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic             clk,
  input  logic             rst,
  uart_mmio_ctrl_if.slave  bus,
  output logic [7:0]       uart_tx_data,
  output logic             uart_tx_valid,
  input  logic             uart_tx_ready,
  input  logic [7:0]       uart_rx_data,
  input  logic             uart_rx_valid,
  output logic             uart_rx_ready
);
  localparam int CW = DEPTH_LOG2 + 1;

  logic          acc, rd_acc, wr_acc;
  logic [4:0]    off;
  logic          rx_pop, rx_full, rx_empty;
  logic [7:0]    rx_head;
  logic [CW-1:0] rx_cnt;
  logic          tx_push, tx_full, tx_empty;
  logic [CW-1:0] tx_cnt;
  logic          ovf;
  logic [31:0]   rdata_nxt;
  logic [31:0]   cyc_val;
  logic          unused_addr;

  assign acc    = ~bus.stall & (bus.io_addr[31:28] == IO_WIN);
  assign rd_acc = bus.io_re & acc;
  assign wr_acc = bus.io_we & acc;
  assign off    = reg_off(bus.io_addr[4:0]);
  assign unused_addr = ^{bus.io_addr[27:5], bus.io_addr[1:0]};

  assign rx_pop  = rd_acc & (off == RX_DATA);
  assign tx_push = wr_acc & (off == TX_DATA);

  assign uart_rx_ready = ~rx_full & ~rst;
  assign uart_tx_valid = ~tx_empty;

  byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .W(8)) u_rx_fifo (
    .clk(clk), .rst(rst),
    .push(uart_rx_valid & uart_rx_ready), .din(uart_rx_data),
    .pop(rx_pop), .dout(rx_head),
    .full(rx_full), .empty(rx_empty), .count(rx_cnt)
  );

  byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .W(8)) u_tx_fifo (
    .clk(clk), .rst(rst),
    .push(tx_push), .din(bus.io_wdata),
    .pop(uart_tx_valid & uart_tx_ready), .dout(uart_tx_data),
    .full(tx_full), .empty(tx_empty), .count(tx_cnt)
  );

  // Sticky until software writes TX_CTRL; set by a store that found TX full.
  always_ff @(posedge clk) begin
    if (rst)                                ovf <= 1'b0;
    else if (tx_push & tx_full)             ovf <= 1'b1;
    else if (wr_acc & (off == TX_CTRL))     ovf <= 1'b0;
  end

`ifdef IO_CYCLE_COUNTER_EN
  logic [31:0] cyc_q;
  always_ff @(posedge clk) begin
    if (rst)                             cyc_q <= '0;
    else if (wr_acc & (off == CYCLE))    cyc_q <= '0;
    else                                 cyc_q <= cyc_q + 32'd1;
  end
  assign cyc_val = cyc_q;
`else
  assign cyc_val = '0;
`endif

  always_comb begin
    rdata_nxt = '0;
    case (off)
      RX_CTRL: begin
        rdata_nxt[NOT_EMPTY]        = ~rx_empty;
        rdata_nxt[OCC_LSB +: CW]    = rx_cnt;
      end
      RX_DATA: rdata_nxt[7:0] = rx_head;
      TX_CTRL: begin
        rdata_nxt[NOT_FULL]         = ~tx_full;
        rdata_nxt[OVERFLOW]         = ovf;
        rdata_nxt[OCC_LSB +: CW]    = tx_cnt;
      end
      CYCLE:   rdata_nxt = cyc_val;
      default: rdata_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)         bus.io_rdata <= '0;
    else if (rd_acc) bus.io_rdata <= rdata_nxt;
  end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed bench for uart_mmio_ctrl (DEPTH_LOG2=3); inputs change 1ns after
// the rising edge and outputs are sampled there too.
module tb_uart_mmio_ctrl;
  logic       clk, rst;
  logic [7:0] uart_tx_data, uart_rx_data;
  logic       uart_tx_valid, uart_tx_ready, uart_rx_valid, uart_rx_ready;
  int         n_chk = 0, n_fail = 0;
  logic [31:0] d, a, b;

  uart_mmio_ctrl_if bus ();

  uart_mmio_ctrl #(.DEPTH_LOG2(3)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid),
    .uart_tx_ready(uart_tx_ready),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
    .uart_rx_ready(uart_rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [31:0] addr, output logic [31:0] data);
    bus.io_addr = addr;
    bus.io_re   = 1'b1;
    tick();
    bus.io_re   = 1'b0;
    data = bus.io_rdata;
  endtask

  task automatic store(input logic [31:0] addr, input logic [7:0] wd);
    bus.io_addr  = addr;
    bus.io_wdata = wd;
    bus.io_we    = 1'b1;
    tick();
    bus.io_we    = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.stall = 1'b0; bus.io_addr = '0; bus.io_re = 1'b0; bus.io_we = 1'b0; bus.io_wdata = '0;
    uart_tx_ready = 1'b0; uart_rx_data = '0; uart_rx_valid = 1'b0;
    tick(); tick();
    chk("rst_rdata",    bus.io_rdata, 32'h0);
    chk("rst_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
    chk("rst_tx_data",  {24'b0, uart_tx_data}, 32'h0);
    chk("rst_rx_ready", {31'b0, uart_rx_ready}, 32'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_rx_ready", {31'b0, uart_rx_ready}, 32'h1);

    // RX path
    uart_rx_valid = 1'b1; uart_rx_data = 8'h41; tick();
    uart_rx_data = 8'h42; tick();
    uart_rx_valid = 1'b0;
    load(32'h8000_0000, d); chk("rx_ctrl_2",   d, 32'h0000_0201);
    load(32'h8000_0004, d); chk("rx_data_41",  d, 32'h41);
    load(32'h8000_0004, d); chk("rx_data_42",  d, 32'h42);
    load(32'h8000_0004, d); chk("rx_data_empty", d, 32'h0);
    load(32'h8000_0000, d); chk("rx_ctrl_empty", d, 32'h0);

    // RX full: 10 offered, 8 accepted
    uart_rx_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("rx_ready_%0d", i), {31'b0, uart_rx_ready}, (i < 8) ? 32'h1 : 32'h0);
      uart_rx_data = 8'h50 + 8'(i);
      tick();
    end
    uart_rx_valid = 1'b0;
    load(32'h8000_0000, d); chk("rx_ctrl_full", d, 32'h0000_0801);
    for (int i = 0; i < 8; i++) begin
      load(32'h8000_0004, d); chk($sformatf("rx_full_data_%0d", i), d, 32'h50 + i);
    end
    load(32'h8000_0000, d); chk("rx_ctrl_drained", d, 32'h0);

    // TX path with overflow
    for (int i = 0; i < 9; i++) store(32'h8000_000C, 8'h60 + 8'(i));
    load(32'h8000_0008, d); chk("tx_ctrl_ovf", d, 32'h0000_0802);
    chk("tx_head_valid", {31'b0, uart_tx_valid}, 32'h1);
    chk("tx_head_data",  {24'b0, uart_tx_data}, 32'h60);
    store(32'h8000_0008, 8'h00);
    load(32'h8000_0008, d); chk("tx_ctrl_clr", d, 32'h0000_0800);
    uart_tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("tx_out_valid_%0d", i), {31'b0, uart_tx_valid}, 32'h1);
      chk($sformatf("tx_out_data_%0d", i),  {24'b0, uart_tx_data}, 32'h60 + i);
      tick();
    end
    chk("tx_drained", {31'b0, uart_tx_valid}, 32'h0);
    uart_tx_ready = 1'b0;
    load(32'h8000_0008, d); chk("tx_ctrl_empty", d, 32'h0000_0001);

    // Stall blocks loads and stores
    uart_rx_valid = 1'b1; uart_rx_data = 8'h77; tick();
    uart_rx_valid = 1'b0;
    load(32'h8000_0000, d); chk("stall_pre", d, 32'h0000_0101);
    bus.stall = 1'b1;
    load(32'h8000_0004, d); chk("stall_hold_rdata", d, 32'h0000_0101);
    store(32'h8000_000C, 8'h99);
    chk("stall_no_push", {31'b0, uart_tx_valid}, 32'h0);
    chk("stall_hold_rdata2", bus.io_rdata, 32'h0000_0101);
    bus.stall = 1'b0;
    load(32'h8000_0000, d); chk("stall_no_pop", d, 32'h0000_0101);
    load(32'h8000_0004, d); chk("stall_byte", d, 32'h77);
    load(32'h8000_0008, d); chk("stall_tx_ctrl", d, 32'h0000_0001);

    // RX empty with simultaneous push and pop
    uart_rx_valid = 1'b1; uart_rx_data = 8'h33;
    load(32'h8000_0004, d);
    uart_rx_valid = 1'b0;
    chk("empty_pushpop_rd", d, 32'h0);
    load(32'h8000_0000, d); chk("empty_pushpop_ctrl", d, 32'h0000_0101);
    load(32'h8000_0004, d); chk("empty_pushpop_byte", d, 32'h33);

    // Unmapped, out-of-window and byte-lane addressing
    load(32'h8000_000B, d); chk("lane_ignored", d, 32'h0000_0001);
    load(32'h4000_0008, d); chk("out_of_window_hold", d, 32'h0000_0001);
    load(32'h8000_0014, d); chk("unmapped_14", d, 32'h0);
    load(32'h8000_000B, d);
    load(32'h8000_001C, d); chk("unmapped_1c", d, 32'h0);

    // Reset mid-operation
    uart_rx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin uart_rx_data = 8'hA0 + 8'(i); tick(); end
    uart_rx_valid = 1'b0;
    for (int i = 0; i < 4; i++) store(32'h8000_000C, 8'hB0 + 8'(i));
    load(32'h8000_0008, d); chk("pre_rst_tx", d, 32'h0000_0401);
    load(32'h8000_0000, d); chk("pre_rst_rx", d, 32'h0000_0301);
    rst = 1'b1; tick();
    chk("mid_rst_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
    chk("mid_rst_rdata",    bus.io_rdata, 32'h0);
    chk("mid_rst_rx_ready", {31'b0, uart_rx_ready}, 32'h0);
    rst = 1'b0; tick();
    load(32'h8000_0000, d); chk("post_rst_rx_occ", d, 32'h0);
    load(32'h8000_0008, d); chk("post_rst_tx_occ", d, 32'h0000_0001);

    // Cycle counter
`ifdef IO_CYCLE_COUNTER_EN
    load(32'h8000_0010, a);
    tick(); tick(); tick(); tick();
    load(32'h8000_0010, b);
    chk("cyc_delta", b - a, 32'd5);
    store(32'h8000_0010, 8'h00);
    load(32'h8000_0010, d); chk("cyc_clr_0", d, 32'd0);
    load(32'h8000_0010, d); chk("cyc_clr_1", d, 32'd1);
`else
    load(32'h8000_0010, a); chk("cyc_absent", a, 32'h0);
    store(32'h8000_0010, 8'hFF);
    tick();
    load(32'h8000_0010, b); chk("cyc_absent_st", b, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
